// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encoding and flag bit positions
//             for the alu_exec execute stage.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding presented by the issuing stage
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Execute FSM state encoding
  localparam int         STATE_W = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bit positions inside the registered flag vector
  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_if
//  Purpose  : Issue / result / write-back bundle between the issuing stage,
//             the execute stage and the register bank.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [2:0]        opcode;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic [ADDR_W-1:0] dst;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              zf;
  logic              cf;
  logic              vf;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // Issuing side: drives requests, observes results and back-pressure
  modport master (
    output start, opcode, op1, op2, dst,
    input  busy, done, result, zf, cf, vf, wr_en, wr_addr
  );

  // Execute stage side
  modport slave (
    input  start, opcode, op1, op2, dst,
    output busy, done, result, zf, cf, vf, wr_en, wr_addr
  );
endinterface : alu_exec_if
`default_nettype wire

// File: rtl/alu_exec_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq
//  Purpose  : Unsigned shift-add multiplier. One multiplier bit per step,
//             LSB first; fixed WIDTH steps regardless of operand values.
//             o_last rises once the final partial product is accumulated.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               i_load,
  input  wire logic               i_step,
  input  wire logic [WIDTH-1:0]   i_a,
  input  wire logic [WIDTH-1:0]   i_b,
  output logic      [2*WIDTH-1:0] o_product,
  output logic                    o_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;

  // Load operands, then accumulate one shifted multiplicand per step until the count expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_last   <= 1'b0;
    end else if (i_step && !r_last) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_last <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_product = r_acc;
  assign o_last    = r_last;

endmodule : mul_seq
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : Execute stage. Captures operands on start, runs a single-cycle
//             logic/arith op or a sequential multiply, then presents a
//             registered result, flags and a one-cycle write-back strobe.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_exec_if.slave   bus
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_busy;
  logic               w_done;

  logic [2:0]         r_opcode;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic [ADDR_W-1:0]  r_dst;

  logic [WIDTH-1:0]   r_result;
  logic [FLAG_W-1:0]  r_flags;

  logic               w_accept;
  logic               w_to_done;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu;
  logic               w_cf;
  logic               w_vf;

  logic [2*WIDTH-1:0] w_product;
  logic               w_mul_last;

  // Only an idle stage takes a request; requests while busy are dropped
  assign w_accept  = bus.start && (r_state == S_IDLE);
  // Result registers load on the single edge that enters DONE
  assign w_to_done = (r_state != S_DONE) && (w_next == S_DONE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: multiply waits for the sequencer, everything else takes one EXEC cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC:  w_next = S_DONE;
      S_MUL: begin
        if (w_mul_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy whenever an op is in flight, done only in DONE
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
  end

  // Operand / opcode / destination capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= OP_ADD;
      r_op1    <= '0;
      r_op2    <= '0;
      r_dst    <= '0;
    end else if (w_accept) begin
      r_opcode <= bus.opcode;
      r_op1    <= bus.op1;
      r_op2    <= bus.op2;
      r_dst    <= bus.dst;
    end
  end

  // Sequential multiplier, loaded straight from the bus on the accept edge
  mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept && (bus.opcode == OP_MUL)),
    .i_step    (r_state == S_MUL),
    .i_a       (bus.op1),
    .i_b       (bus.op2),
    .o_product (w_product),
    .o_last    (w_mul_last)
  );

  assign w_sum  = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_diff = {1'b0, r_op1} - {1'b0, r_op2};

  // Result and carry/overflow selection from the captured operands
  always_comb begin
    w_alu = '0;
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    case (r_opcode)
      OP_ADD: begin
        w_alu = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (r_op1[WIDTH-1] == r_op2[WIDTH-1]) && (w_sum[WIDTH-1] != r_op1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu = w_diff[WIDTH-1:0];
        w_cf  = w_diff[WIDTH];   // borrow out == op1 < op2 unsigned
        w_vf  = (r_op1[WIDTH-1] != r_op2[WIDTH-1]) && (w_diff[WIDTH-1] != r_op1[WIDTH-1]);
      end
      OP_AND:  w_alu = r_op1 & r_op2;
      OP_OR:   w_alu = r_op1 | r_op2;
      OP_XOR:  w_alu = r_op1 ^ r_op2;
      OP_SHL:  w_alu = r_op1 << r_op2[3:0];
      OP_SHR:  w_alu = r_op1 >> r_op2[3:0];
      OP_MUL: begin
        w_alu = w_product[WIDTH-1:0];
        w_cf  = |w_product[2*WIDTH-1:WIDTH];
      end
      default: w_alu = '0;
    endcase
  end

  // Result and flags hold between completions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_to_done) begin
      r_result        <= w_alu;
      r_flags[FLAG_Z] <= (w_alu == '0);
      r_flags[FLAG_C] <= w_cf;
      r_flags[FLAG_V] <= w_vf;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.wr_en   = w_done;
  assign bus.wr_addr = r_dst;
  assign bus.result  = r_result;
  assign bus.zf      = r_flags[FLAG_Z];
  assign bus.cf      = r_flags[FLAG_C];
  assign bus.vf      = r_flags[FLAG_V];

endmodule : alu_exec
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Directed self-checking bench for alu_exec.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_exec_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  alu_exec #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present a request before a rising edge; that edge is the accept edge N
  task automatic issue(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = opc;
    bus.op1    = a;
    bus.op2    = b;
    bus.dst    = d;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // Returns the edge index (relative to N) at which done is first sampled high; 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] d, input logic [15:0] e_res,
                        input logic e_z, input logic e_c, input logic e_v, input int e_lat);
    int lat;
    issue(opc, a, b, d);
    wait_done(lat);
    chk({tag, ".lat"},    32'(lat), 32'(e_lat));
    chk({tag, ".result"}, 32'(bus.result), 32'(e_res));
    chk({tag, ".zf"},     32'(bus.zf), 32'(e_z));
    chk({tag, ".cf"},     32'(bus.cf), 32'(e_c));
    chk({tag, ".vf"},     32'(bus.vf), 32'(e_v));
    chk({tag, ".wr_en"},  32'(bus.wr_en), 32'd1);
    chk({tag, ".wr_addr"},32'(bus.wr_addr), 32'(d));
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle"},       32'(bus.busy), 32'd0);
    chk({tag, ".hold"},       32'(bus.result), 32'(e_res));
  endtask

  initial begin
    int dones;
    int lat;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = OP_ADD;
    bus.op1    = '0;
    bus.op2    = '0;
    bus.dst    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",    32'(bus.busy), 32'd0);
    chk("rst.done",    32'(bus.done), 32'd0);
    chk("rst.wr_en",   32'(bus.wr_en), 32'd0);
    chk("rst.result",  32'(bus.result), 32'd0);
    chk("rst.flags",   32'({bus.zf, bus.cf, bus.vf}), 32'd0);
    chk("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle operations: done at N+2
    //            tag      op      op1       op2       dst   result    z     c     v    lat
    run_op("add",    OP_ADD, 16'h0008, 16'h0038, 4'd3, 16'h0040, 1'b0, 1'b0, 1'b0, 2);
    run_op("add_c",  OP_ADD, 16'hFFFF, 16'h0001, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b0, 2);
    run_op("add_v",  OP_ADD, 16'h7FFF, 16'h0001, 4'd2, 16'h8000, 1'b0, 1'b0, 1'b1, 2);
    run_op("sub_b",  OP_SUB, 16'h0005, 16'h0008, 4'd4, 16'hFFFD, 1'b0, 1'b1, 1'b0, 2);
    run_op("sub_v",  OP_SUB, 16'h8000, 16'h0001, 4'd5, 16'h7FFF, 1'b0, 1'b0, 1'b1, 2);
    run_op("and",    OP_AND, 16'hF0F0, 16'h0FF0, 4'd6, 16'h00F0, 1'b0, 1'b0, 1'b0, 2);
    run_op("or",     OP_OR,  16'hF000, 16'h000F, 4'd7, 16'hF00F, 1'b0, 1'b0, 1'b0, 2);
    run_op("xor",    OP_XOR, 16'hAAAA, 16'hAAAA, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    run_op("shl15",  OP_SHL, 16'h0001, 16'h000F, 4'd9, 16'h8000, 1'b0, 1'b0, 1'b0, 2);
    run_op("shl_lo", OP_SHL, 16'h0001, 16'h0013, 4'd10,16'h0008, 1'b0, 1'b0, 1'b0, 2);
    run_op("shr4",   OP_SHR, 16'h8000, 16'h0004, 4'd11,16'h0800, 1'b0, 1'b0, 1'b0, 2);

    // Multiply: done at N+18
    run_op("mul_hi", OP_MUL, 16'h0100, 16'h0300, 4'd12,16'h0000, 1'b1, 1'b1, 1'b0, 18);
    run_op("mul",    OP_MUL, 16'h0008, 16'h0038, 4'd13,16'h01C0, 1'b0, 1'b0, 1'b0, 18);
    run_op("mul_ff", OP_MUL, 16'hFFFF, 16'hFFFF, 4'd14,16'h0001, 1'b0, 1'b1, 1'b0, 18);
    run_op("mul_0",  OP_MUL, 16'h0000, 16'h1234, 4'd15,16'h0000, 1'b1, 1'b0, 1'b0, 18);

    // start held high through a multiply: only the first op runs
    issue(OP_MUL, 16'h0003, 16'h0005, 4'd6);
    bus.start  = 1'b1;
    bus.opcode = OP_ADD;
    bus.op1    = 16'h1111;
    bus.op2    = 16'h2222;
    bus.dst    = 4'd9;
    dones      = 0;
    chk("bp.busy_n1", 32'(bus.busy), 32'd1);
    for (int k = 2; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1) begin
        chk("bp.busy_hold", 32'(bus.busy), 32'd1);
      end
      if (bus.done === 1'b1) dones++;
    end
    bus.start = 1'b0;
    chk("bp.result",  32'(bus.result), 32'h000F);
    chk("bp.wr_addr", 32'(bus.wr_addr), 32'd6);
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) dones++;
    chk("bp.dones", 32'(dones), 32'd1);
    chk("bp.idle",  32'(bus.busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("bp.no_extra", 32'(dones), 32'd1);

    // Asynchronous reset in the middle of a multiply
    issue(OP_MUL, 16'h0007, 16'h0009, 4'd11);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy",    32'(bus.busy), 32'd0);
    chk("arst.done",    32'(bus.done), 32'd0);
    chk("arst.wr_en",   32'(bus.wr_en), 32'd0);
    chk("arst.result",  32'(bus.result), 32'd0);
    chk("arst.flags",   32'({bus.zf, bus.cf, bus.vf}), 32'd0);
    chk("arst.wr_addr", 32'(bus.wr_addr), 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) dones++;
    end
    chk("arst.no_wb", 32'(dones), 32'd0);
    run_op("post_rst", OP_ADD, 16'h0008, 16'h0038, 4'd5, 16'h0040, 1'b0, 1'b0, 1'b0, 2);

    // Completion with no request must never appear
    wait_done(lat);
    chk("quiet", 32'(lat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_exec
`default_nettype wire
